// File: rtl/game_pkg.sv
// Shared game constants: playfield geometry, spawn point, colours and blink state encoding.
package game_pkg;

   localparam int TILE_SIZE   = 32;
   localparam int GRID_COLS   = 20;
   localparam int GRID_ROWS   = 15;
   localparam int ACTIVE_ROWS = 480;

   localparam int SPAWN_X = 10;
   localparam int SPAWN_Y = 15;

   // Colours are packed {R[2:0], G[2:0], B[2:0]}.
   localparam logic [8:0] RGB_BLACK  = 9'b000_000_000;
   localparam logic [8:0] RGB_YELLOW = 9'b111_111_000;

   typedef enum logic {
      BLINK_IDLE = 1'b0,
      BLINK_ON   = 1'b1
   } blink_state_t;

endpackage

// File: rtl/player_sprite_rom.sv
// Combinational 8x8 player bitmap: row 0 is the top, bit 7 is the leftmost pixel.
module player_sprite_rom (
   input  logic [2:0] row_idx,
   output logic [7:0] row_bits
);

   always_comb begin
      // NOTE: default assignment first so every path drives row_bits and no latch is inferred.
      row_bits = 8'b0000_0000;
      unique case (row_idx)
         3'd0: row_bits = 8'b0011_1100;
         3'd1: row_bits = 8'b0111_1110;
         3'd2: row_bits = 8'b1101_1011;
         3'd3: row_bits = 8'b1111_1111;
         3'd4: row_bits = 8'b1111_1111;
         3'd5: row_bits = 8'b0110_0110;
         3'd6: row_bits = 8'b0100_0010;
         3'd7: row_bits = 8'b0010_0100;
         default: row_bits = 8'b0000_0000;
      endcase
   end

endmodule

// File: rtl/player_renderer.sv
// Player sprite renderer: per-frame position snapshot, tile hit test, 3-stage pixel pipeline.
// Define PLAYER_BLINK_EN to compile in the respawn blink FSM.
module player_renderer
   import game_pkg::*;
#(
   parameter int         TILE_SIZE    = game_pkg::TILE_SIZE,
   parameter int         GRID_COLS    = game_pkg::GRID_COLS,
   parameter int         GRID_ROWS    = game_pkg::GRID_ROWS,
   parameter int         ACTIVE_ROWS  = game_pkg::ACTIVE_ROWS,
   parameter logic [8:0] SPRITE_RGB   = game_pkg::RGB_YELLOW,
   parameter int         BLINK_FRAMES = 64,
   parameter int         BLINK_PERIOD = 8
)(
   input  logic       i_Clk,
   input  logic       i_reset,
   input  logic [9:0] i_player_x,
   input  logic [9:0] i_player_y,
   input  logic       i_player_reset,
   input  logic [9:0] i_col_count,
   input  logic [9:0] i_row_count,
   input  logic       i_video_active,
   output logic       o_video_active,
   output logic       o_pixel_on,
   output logic [2:0] o_red,
   output logic [2:0] o_green,
   output logic [2:0] o_blue
);

   localparam int TILE_SHIFT = $clog2(TILE_SIZE);
   localparam int IDX_SHIFT  = TILE_SHIFT - 3;

   localparam logic [9:0] TILE_W    = 10'(TILE_SIZE);
   localparam logic [9:0] COLS_W    = 10'(GRID_COLS);
   localparam logic [9:0] ROWS_W    = 10'(GRID_ROWS);
   localparam logic [9:0] ACTIVE_W  = 10'(ACTIVE_ROWS);
   localparam logic [9:0] SPAWN_X_W = 10'(SPAWN_X);
   localparam logic [9:0] SPAWN_Y_W = 10'(SPAWN_Y);

   logic       frame_tick;
   logic [9:0] sx, sy;
   logic       blink_visible;

   assign frame_tick = (i_row_count == ACTIVE_W) && (i_col_count == 10'd0);

   // Snapshot in vertical blanking so mid-frame moves never tear the sprite.
   always_ff @(posedge i_Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (i_reset) begin
         sx <= SPAWN_X_W;
         sy <= SPAWN_Y_W;
      end else if (frame_tick) begin
         sx <= i_player_x;
         sy <= i_player_y;
      end
   end

`ifdef PLAYER_BLINK_EN
   localparam int         BLINK_BIT = $clog2(BLINK_PERIOD);
   localparam logic [6:0] FCNT_LAST = 7'(BLINK_FRAMES - 1);

   blink_state_t state;
   logic [6:0]   fcnt;
   logic [6:0]   fcnt_next;

   assign fcnt_next = fcnt + 7'd1;

   // Respawn pulse wins over the frame tick, so a coincident tick restarts at fcnt=0.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         state         <= BLINK_IDLE;
         fcnt          <= 7'd0;
         blink_visible <= 1'b1;
      end else if (i_player_reset) begin
         state         <= BLINK_ON;
         fcnt          <= 7'd0;
         blink_visible <= 1'b1;
      end else if ((state == BLINK_ON) && frame_tick) begin
         if (fcnt == FCNT_LAST) begin
            state         <= BLINK_IDLE;
            fcnt          <= 7'd0;
            blink_visible <= 1'b1;
         end else begin
            fcnt          <= fcnt_next;
            blink_visible <= ~fcnt_next[BLINK_BIT];
         end
      end
   end
`else
   logic unused_player_reset;

   assign blink_visible       = 1'b1;
   assign unused_player_reset = i_player_reset;
`endif

   logic [9:0] sx_m1, sy_m1, ox, oy, dx, dy;
   logic       pos_valid, hit;

   always_comb begin
      sx_m1     = sx - 10'd1;
      sy_m1     = sy - 10'd1;
      ox        = sx_m1 << TILE_SHIFT;
      oy        = sy_m1 << TILE_SHIFT;
      dx        = i_col_count - ox;
      dy        = i_row_count - oy;
      pos_valid = (sx >= 10'd1) && (sx <= COLS_W) && (sy >= 10'd1) && (sy <= ROWS_W);
      // Tile never reaches the 10-bit limit for valid positions, so dx < TILE is an exact upper bound.
      hit       = pos_valid && (i_col_count >= ox) && (dx < TILE_W)
                            && (i_row_count >= oy) && (dy < TILE_W);
   end

   logic       s1_hit, s1_active;
   logic [2:0] s1_dx_idx, s1_dy_idx;
   logic       s2_pix, s2_active;
   logic [7:0] rom_row;

   player_sprite_rom u_rom (
      .row_idx  (s1_dy_idx),
      .row_bits (rom_row)
   );

   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         s1_hit         <= 1'b0;
         s1_active      <= 1'b0;
         s1_dx_idx      <= 3'd0;
         s1_dy_idx      <= 3'd0;
         s2_pix         <= 1'b0;
         s2_active      <= 1'b0;
         o_video_active <= 1'b0;
         o_pixel_on     <= 1'b0;
         {o_red, o_green, o_blue} <= RGB_BLACK;
      end else begin
         s1_hit         <= hit & blink_visible;
         s1_active      <= i_video_active;
         s1_dx_idx      <= dx[IDX_SHIFT +: 3];
         s1_dy_idx      <= dy[IDX_SHIFT +: 3];
         s2_pix         <= s1_hit & rom_row[3'd7 - s1_dx_idx];
         s2_active      <= s1_active;
         o_video_active <= s2_active;
         o_pixel_on     <= s2_pix & s2_active;
         {o_red, o_green, o_blue} <= (s2_pix & s2_active) ? SPRITE_RGB : RGB_BLACK;
      end
   end

endmodule

// File: tb/tb_player_renderer.sv
// Directed bench for player_renderer: bitmap table, latency, snapshot, validity, blink and reset.
module tb_player_renderer;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] px, py, col, row;
   logic       preset, act;
   logic       o_act, o_on;
   logic [2:0] o_r, o_g, o_b;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [8:0] YELLOW = 9'b111_111_000;

   always #5 clk = ~clk;

   player_renderer dut (
      .i_Clk          (clk),
      .i_reset        (rst),
      .i_player_x     (px),
      .i_player_y     (py),
      .i_player_reset (preset),
      .i_col_count    (col),
      .i_row_count    (row),
      .i_video_active (act),
      .o_video_active (o_act),
      .o_pixel_on     (o_on),
      .o_red          (o_r),
      .o_green        (o_g),
      .o_blue         (o_b)
   );

   typedef struct {
      logic [9:0] col;
      logic [9:0] row;
      logic       act;
      logic       exp_on;
      string      name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One-cycle pixel, then idle; outputs sampled 3 cycles after the pixel was presented.
   task automatic check_pixel(input string name, input logic [9:0] c, input logic [9:0] r,
                              input logic a, input logic exp_on);
      @(negedge clk);
      col = c; row = r; act = a;
      @(negedge clk);
      col = 10'd0; row = 10'd0; act = 1'b0;
      repeat (2) @(negedge clk);
      check({name, "_on"}, 32'(o_on), 32'(exp_on));
      check({name, "_rgb"}, 32'({o_r, o_g, o_b}), 32'(exp_on ? YELLOW : 9'd0));
      check({name, "_act"}, 32'(o_act), 32'(a));
   endtask

   task automatic frame_tick(input logic with_pulse);
      @(negedge clk);
      row = 10'd480; col = 10'd0; act = 1'b0; preset = with_pulse;
      @(negedge clk);
      row = 10'd0; col = 10'd0; preset = 1'b0;
   endtask

   task automatic pulse_player_reset();
      @(negedge clk);
      preset = 1'b1;
      @(negedge clk);
      preset = 1'b0;
   endtask

   function automatic logic blink_vis(input int f);
`ifdef PLAYER_BLINK_EN
      return (f >= 64) || (((f >> 3) & 1) == 0);
`else
      return 1'b1;
`endif
   endfunction

   vec_t vecs[14];

   initial begin
      // Default spawn (10,15): tile origin (288,448).
      vecs[0]  = '{10'd290, 10'd448, 1'b1, 1'b0, "row0_left_clear"};
      vecs[1]  = '{10'd298, 10'd448, 1'b1, 1'b1, "row0_idx2_set"};
      vecs[2]  = '{10'd287, 10'd460, 1'b1, 1'b0, "left_of_tile"};
      vecs[3]  = '{10'd288, 10'd456, 1'b1, 1'b1, "row2_idx0_set"};
      vecs[4]  = '{10'd296, 10'd456, 1'b1, 1'b0, "row2_eye_clear"};
      vecs[5]  = '{10'd319, 10'd460, 1'b1, 1'b1, "right_edge_in"};
      vecs[6]  = '{10'd320, 10'd460, 1'b1, 1'b0, "right_edge_out"};
      vecs[7]  = '{10'd300, 10'd479, 1'b1, 1'b0, "row7_idx3_clear"};
      vecs[8]  = '{10'd296, 10'd479, 1'b1, 1'b1, "row7_idx2_set"};
      vecs[9]  = '{10'd300, 10'd447, 1'b1, 1'b0, "above_tile"};
      vecs[10] = '{10'd304, 10'd468, 1'b1, 1'b0, "row5_idx4_clear"};
      vecs[11] = '{10'd292, 10'd468, 1'b1, 1'b1, "row5_idx1_set"};
      vecs[12] = '{10'd298, 10'd448, 1'b0, 1'b0, "inactive_hit"};
      vecs[13] = '{10'd312, 10'd452, 1'b1, 1'b1, "row1_idx6_set"};

      rst = 1'b1; px = 10'd10; py = 10'd15; preset = 1'b0;
      col = 10'd0; row = 10'd0; act = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_on", 32'(o_on), 32'd0);
      check("reset_act", 32'(o_act), 32'd0);
      check("reset_rgb", 32'({o_r, o_g, o_b}), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      foreach (vecs[i]) check_pixel(vecs[i].name, vecs[i].col, vecs[i].row, vecs[i].act, vecs[i].exp_on);

      // Latency: pixel presented at N appears at N+3, not N+2.
      @(negedge clk);
      col = 10'd298; row = 10'd448; act = 1'b1;
      @(negedge clk);
      col = 10'd0; row = 10'd0; act = 1'b0;
      @(negedge clk);
      check("lat_n2_on", 32'(o_on), 32'd0);
      check("lat_n2_act", 32'(o_act), 32'd0);
      @(negedge clk);
      check("lat_n3_on", 32'(o_on), 32'd1);
      check("lat_n3_act", 32'(o_act), 32'd1);

      // Mid-frame move only takes effect after the next frame tick.
      px = 10'd11;
      check_pixel("mid_old_pos", 10'd298, 10'd448, 1'b1, 1'b1);
      check_pixel("mid_new_pos", 10'd330, 10'd448, 1'b1, 1'b0);
      frame_tick(1'b0);
      check_pixel("next_new_pos", 10'd330, 10'd448, 1'b1, 1'b1);
      check_pixel("next_old_pos", 10'd298, 10'd448, 1'b1, 1'b0);

      // Out-of-range positions blank the sprite; wrapped origins must not leak through.
      px = 10'd0; frame_tick(1'b0);
      check_pixel("x0_wrapped", 10'd1002, 10'd448, 1'b1, 1'b0);
      check_pixel("x0_spawn", 10'd298, 10'd448, 1'b1, 1'b0);
      px = 10'd21; frame_tick(1'b0);
      check_pixel("x21", 10'd650, 10'd448, 1'b1, 1'b0);
      px = 10'd10; py = 10'd16; frame_tick(1'b0);
      check_pixel("y16", 10'd298, 10'd480, 1'b1, 1'b0);
      px = 10'd20; py = 10'd15; frame_tick(1'b0);
      check_pixel("x20_edge", 10'd618, 10'd448, 1'b1, 1'b1);
      px = 10'd1; py = 10'd1; frame_tick(1'b0);
      check_pixel("x1y1_corner", 10'd10, 10'd0, 1'b1, 1'b1);
      px = 10'd10; py = 10'd15; frame_tick(1'b0);

      // Respawn blink sequence (ignored without the blink build).
      pulse_player_reset();
      for (int f = 0; f < 70; f++) begin
         check_pixel($sformatf("blink_f%0d", f), 10'd298, 10'd448, 1'b1, blink_vis(f));
         frame_tick(1'b0);
      end

      // Restart at frame 20, pulse coinciding with the frame tick.
      pulse_player_reset();
      for (int f = 0; f < 20; f++) frame_tick(1'b0);
      frame_tick(1'b1);
      for (int f = 0; f < 12; f++) begin
         check_pixel($sformatf("restart_f%0d", f), 10'd298, 10'd448, 1'b1, blink_vis(f));
         frame_tick(1'b0);
      end
      repeat (4) frame_tick(1'b0);

      // Reset while the sprite is drawn: shadow back to spawn, FSM idle, pipeline cleared.
      px = 10'd11; frame_tick(1'b0);
      @(negedge clk);
      col = 10'd332; row = 10'd449; act = 1'b1; px = 10'd3;
      repeat (3) @(negedge clk);
      check("pre_rst_on", 32'(o_on), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_next_on", 32'(o_on), 32'd0);
      check("rst_next_act", 32'(o_act), 32'd0);
      check("rst_next_rgb", 32'({o_r, o_g, o_b}), 32'd0);
      row = 10'd480; col = 10'd0;
      @(negedge clk);
      row = 10'd449; col = 10'd300;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("refill_c1_on", 32'(o_on), 32'd0);
      @(negedge clk);
      check("refill_c2_on", 32'(o_on), 32'd0);
      @(negedge clk);
      check("refill_c3_on", 32'(o_on), 32'd1);
      check("refill_c3_act", 32'(o_act), 32'd1);
      act = 1'b0; col = 10'd0; row = 10'd0;
      check_pixel("post_rst_old", 10'd332, 10'd449, 1'b1, 1'b0);
      px = 10'd10;
      for (int f = 0; f < 10; f++) begin
         frame_tick(1'b0);
         check_pixel($sformatf("post_rst_f%0d", f), 10'd300, 10'd449, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
